// File: rtl/systolic_feeder_if.sv
// Operand handshake and skewed-stream bus between the feeder, its producer and the systolic core.
interface systolic_feeder_if #(
    parameter int unsigned N     = 2,
    parameter int unsigned WIDTH = 4
);
    logic                                in_valid;
    logic                                in_ready;
    logic [N-1:0][N-1:0][WIDTH-1:0]      mat_a;
    logic [N-1:0][N-1:0][WIDTH-1:0]      mat_b;
    logic                                finish;
    logic                                start;
    logic [1:0][N-1:0][WIDTH-1:0]        array;
    logic                                busy;
    logic                                done;
    logic                                err;

    modport master (
        output in_valid, mat_a, mat_b, finish,
        input  in_ready, start, array, busy, done, err
    );

    modport slave (
        input  in_valid, mat_a, mat_b, finish,
        output in_ready, start, array, busy, done, err
    );
endinterface

// File: rtl/systolic_feeder.sv
// Latches an A/B operand pair and replays it as the diagonally skewed edge stream for the
// systolic core, then waits (bounded) for the core's finish before reporting done or err.
module systolic_feeder #(
    parameter int unsigned N       = 2,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst_n,
    systolic_feeder_if.slave bus
);
    localparam int unsigned TW = (N > 1) ? $clog2(2 * N) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef logic [N-1:0][N-1:0][WIDTH-1:0] mat_t;
    typedef logic [1:0][N-1:0][WIDTH-1:0]   lanes_t;
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

    localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
    localparam logic [CW-1:0] W_LAST = CW'(TIMEOUT - 1);

    state_t          state;
    logic [TW-1:0]   t;
    logic [CW-1:0]   wcnt;
    mat_t            a_q;
    mat_t            b_q;
    lanes_t          lanes;
    logic            start_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    // Edge vectors for stream cycle t: row i of A and column j of B are delayed by their lane index.
    function automatic lanes_t skew(input mat_t a, input mat_t b, input logic [TW-1:0] tt);
        lanes_t s;
        int     ti;
        s = '0;
        for (int i = 0; i < int'(N); i++) begin
            ti = int'(tt) - i;
            if (ti >= 0 && ti < int'(N)) begin
                s[0][IW'(i)] = a[IW'(i)][IW'(ti)];
                s[1][IW'(i)] = b[IW'(ti)][IW'(i)];
            end
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            t       <= '0;
            wcnt    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lanes   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lanes   <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.mat_a;
                        b_q     <= bus.mat_b;
                        t       <= '0;
                        lanes   <= skew(bus.mat_a, bus.mat_b, '0);
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (t == T_LAST) begin
                        wcnt  <= '0;
                        state <= S_WAIT;
                    end else begin
                        t     <= t + TW'(1);
                        lanes <= skew(a_q, b_q, t + TW'(1));
                    end
                end
                S_WAIT: begin
                    // finish wins over a timeout landing on the same edge
                    if (bus.finish) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else if (wcnt == W_LAST) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        wcnt   <= '0;
                        state  <= S_IDLE;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                S_DONE: begin
                    wcnt  <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state == S_IDLE);
    assign bus.start    = start_q;
    assign bus.array    = lanes;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
